// File: rtl/uart_rx_frame_ctrl.sv
// UART receive frame controller: start/data/parity/stop sequencing,
// edge and bit counters, word assembly and one-cycle status pulses.
module uart_rx_frame_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESC_W    = 6,
  parameter int MSB_FIRST  = 0
) (
  input  logic                  clk,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  sampled_bit,
  input  logic [PRESC_W-1:0]    prescale,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic [PRESC_W-1:0]    edge_cnt,
  output logic [3:0]            bit_cnt,
  output logic                  data_samp_en,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err,
  output logic                  strt_glitch,
  output logic                  break_det
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP1  = 3'd4,
    S_STOP2  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  localparam logic [3:0] LAST_DBIT = 4'(DATA_WIDTH);

  state_t                state_q, state_d;
  logic [PRESC_W-1:0]    edge_q, edge_d;
  logic [3:0]            bit_q, bit_d;
  logic [PRESC_W-1:0]    presc_q, presc_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic                  st2_q, st2_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  acc_q, acc_d;
  logic                  par_flag_q, par_flag_d;
  logic                  stp_flag_q, stp_flag_d;
  logic [DATA_WIDTH-1:0] pdata_q, pdata_d;
  logic                  dv_q, dv_d;
  logic                  pe_q, pe_d;
  logic                  se_q, se_d;
  logic                  sg_q, sg_d;
  logic                  bd_q, bd_d;

  logic last;
  logic start_go;
  logic done_go;

  assign last = (edge_q == presc_q - PRESC_W'(1));

  // Next-state, counter, datapath and pulse computation
  always_comb begin
    state_d    = state_q;
    edge_d     = '0;
    bit_d      = '0;
    presc_d    = presc_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    st2_d      = st2_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    par_flag_d = par_flag_q;
    stp_flag_d = stp_flag_q;
    pdata_d    = pdata_q;
    dv_d       = 1'b0;
    pe_d       = 1'b0;
    se_d       = 1'b0;
    sg_d       = 1'b0;
    bd_d       = 1'b0;
    start_go   = 1'b0;
    done_go    = 1'b0;

    if (state_q == S_START || state_q == S_DATA ||
        state_q == S_PARITY || state_q == S_STOP1 ||
        state_q == S_STOP2) begin
      if (last) begin
        edge_d = '0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + PRESC_W'(1);
        bit_d  = bit_q;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (!RX_IN) start_go = 1'b1;
      end
      S_START: begin
        if (last) begin
          if (sampled_bit) begin
            state_d = S_IDLE;
            bit_d   = '0;
            sg_d    = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (last) begin
          if (MSB_FIRST != 0)
            shift_d = {shift_q[DATA_WIDTH-2:0], sampled_bit};
          else
            shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
          acc_d = acc_q ^ sampled_bit;
          if (bit_q == LAST_DBIT)
            state_d = par_en_q ? S_PARITY : S_STOP1;
        end
      end
      S_PARITY: begin
        if (last) begin
          if (sampled_bit != (acc_q ^ par_typ_q))
            par_flag_d = 1'b1;
          state_d = S_STOP1;
        end
      end
      S_STOP1: begin
        if (last) begin
          if (!sampled_bit) stp_flag_d = 1'b1;
          if (st2_q) begin
            state_d = S_STOP2;
          end else begin
            state_d = S_DONE;
            done_go = 1'b1;
          end
        end
      end
      S_STOP2: begin
        if (last) begin
          if (!sampled_bit) stp_flag_d = 1'b1;
          state_d = S_DONE;
          done_go = 1'b1;
        end
      end
      S_DONE: begin
        if (!RX_IN) start_go = 1'b1;
        else state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Frame end: publish the word or the error pulses
    if (done_go) begin
      edge_d = '0;
      bit_d  = '0;
      if (!par_flag_d && !stp_flag_d) begin
        dv_d    = 1'b1;
        pdata_d = shift_q;
      end
      pe_d = par_flag_d;
      se_d = stp_flag_d;
      bd_d = stp_flag_d && (shift_q == '0);
    end

    // New frame: latch configuration, clear accumulators
    if (start_go) begin
      state_d    = S_START;
      edge_d     = '0;
      bit_d      = '0;
      presc_d    = prescale;
      par_en_d   = PAR_EN;
      par_typ_d  = PAR_TYP;
      st2_d      = STOP2;
      acc_d      = 1'b0;
      par_flag_d = 1'b0;
      stp_flag_d = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (RST) begin
      state_q    <= S_IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      presc_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      st2_q      <= 1'b0;
      shift_q    <= '0;
      acc_q      <= 1'b0;
      par_flag_q <= 1'b0;
      stp_flag_q <= 1'b0;
      pdata_q    <= '0;
      dv_q       <= 1'b0;
      pe_q       <= 1'b0;
      se_q       <= 1'b0;
      sg_q       <= 1'b0;
      bd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      presc_q    <= presc_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      st2_q      <= st2_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      par_flag_q <= par_flag_d;
      stp_flag_q <= stp_flag_d;
      pdata_q    <= pdata_d;
      dv_q       <= dv_d;
      pe_q       <= pe_d;
      se_q       <= se_d;
      sg_q       <= sg_d;
      bd_q       <= bd_d;
    end
  end

  assign data_samp_en = (state_q == S_START)  ||
                        (state_q == S_DATA)   ||
                        (state_q == S_PARITY) ||
                        (state_q == S_STOP1)  ||
                        (state_q == S_STOP2);

  assign edge_cnt    = edge_q;
  assign bit_cnt     = bit_q;
  assign P_DATA      = pdata_q;
  assign data_valid  = dv_q;
  assign par_err     = pe_q;
  assign stp_err     = se_q;
  assign strt_glitch = sg_q;
  assign break_det   = bd_q;

endmodule
